// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  localparam int MUL_LAT_DEFAULT = 9;
  localparam int DIV_ITERS       = 32;

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// with the sign fix-up applied combinationally on the way out.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        running_q;
  logic [5:0]  iter_q;
  logic [31:0] q_q;
  logic [31:0] r_q;
  logic [31:0] d_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] shifted;
  logic [32:0] diff;

  assign dvd_neg = is_signed & dividend[31];
  assign dvs_neg = is_signed & divisor[31];
  assign dvd_mag = dvd_neg ? (~dividend + 32'd1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 32'd1) : divisor;

  // Partial remainder shifted left with the next dividend bit; a clear bit 32
  // in the difference means the divisor fits.
  assign shifted = {r_q, q_q[31]};
  assign diff    = shifted - {1'b0, d_q};
  assign done    = running_q && (iter_q == 6'(DIV_ITERS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running_q  <= 1'b0;
      iter_q     <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (abort) begin
      running_q <= 1'b0;
      iter_q    <= '0;
    end else if (start) begin
      iter_q <= '0;
      if (divisor == 32'd0) begin
        // Zero divisor finishes immediately with all-ones quotient, raw dividend.
        running_q  <= 1'b0;
        q_q        <= '1;
        r_q        <= dividend;
        d_q        <= '0;
        neg_quot_q <= 1'b0;
        neg_rem_q  <= 1'b0;
      end else begin
        running_q  <= 1'b1;
        q_q        <= dvd_mag;
        r_q        <= '0;
        d_q        <= dvs_mag;
        neg_quot_q <= dvd_neg ^ dvs_neg;
        neg_rem_q  <= dvd_neg;
      end
    end else if (running_q) begin
      if (!diff[32]) begin
        r_q <= diff[31:0];
        q_q <= {q_q[30:0], 1'b1};
      end else begin
        r_q <= shifted[31:0];
        q_q <= {q_q[30:0], 1'b0};
      end
      iter_q <= iter_q + 6'd1;
      if (done) begin
        running_q <= 1'b0;
      end
    end
  end

  assign quot = neg_quot_q ? (~q_q + 32'd1) : q_q;
  assign rem  = neg_rem_q  ? (~r_q + 32'd1) : r_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: drives the external pipelined multiplier, runs the
// internal divider, stalls EX while busy and issues one HI/LO write per op.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic        except_i,
  input  logic        stall_ext_i,
  output logic        mul_ce_o,
  output logic        mul_sclr_o,
  output logic        mul_signed_o,
  input  logic [63:0] mul_p_i,
  output logic        hi_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o,
  output logic        busy_o
);

  localparam int              CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  muldiv_state_e    state_q;
  muldiv_state_e    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             is_mul_q;
  logic             is_mul_d;

  muldiv_op_e  op;
  logic        kill;
  logic        div_start;
  logic        div_abort;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  assign op   = muldiv_op_e'(op_i);
  assign kill = flush_i | except_i;

  div_iter u_div_iter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (div_start),
    .abort     (div_abort),
    .is_signed (~op_i[0]),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
    end
  end

  // Outputs are also forced low while reset is asserted so an in-flight
  // start_i cannot leak a stall or clock enable during reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    mul_ce_o   = 1'b0;
    mul_sclr_o = 1'b0;
    stall_o    = 1'b0;
    hi_we_o    = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;

    if (rst_ni) begin
      if (kill) begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        mul_sclr_o = 1'b1;
        div_abort  = 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              stall_o = 1'b1;
              if (op == MULT || op == MULTU) begin
                mul_ce_o = 1'b1;
                is_mul_d = 1'b1;
                cnt_d    = CNT_W'(1);
                state_d  = ST_MUL;
              end else begin
                is_mul_d  = 1'b0;
                div_start = 1'b1;
                state_d   = (reg2_i == 32'd0) ? ST_DONE : ST_DIV;
              end
            end
          end
          ST_MUL: begin
            stall_o  = 1'b1;
            mul_ce_o = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
            end
          end
          ST_DIV: begin
            stall_o = 1'b1;
            if (div_done) begin
              state_d = ST_DONE;
            end
          end
          ST_DONE: begin
            // The instruction retires here; start_i next cycle is a new one.
            if (!stall_ext_i) begin
              hi_we_o = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mul_signed_o = mul_ce_o & ~op_i[0];
  assign busy_o       = (state_q != ST_IDLE);

  assign hi_o = hi_we_o ? (is_mul_q ? mul_p_i[63:32] : div_rem)  : 32'd0;
  assign lo_o = hi_we_o ? (is_mul_q ? mul_p_i[31:0]  : div_quot) : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized ops
// against an arithmetic reference model and a behavioural multiplier pipeline.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = MUL_LAT_DEFAULT;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        start_i     = 1'b0;
  logic [1:0]  op_i        = 2'b00;
  logic [31:0] reg1_i      = 32'd0;
  logic [31:0] reg2_i      = 32'd0;
  logic        flush_i     = 1'b0;
  logic        except_i    = 1'b0;
  logic        stall_ext_i = 1'b0;
  logic        mul_ce_o;
  logic        mul_sclr_o;
  logic        mul_signed_o;
  logic [63:0] mul_p_i;
  logic        hi_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] mulPipe [MUL_LAT];

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .op_i         (op_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .flush_i      (flush_i),
    .except_i     (except_i),
    .stall_ext_i  (stall_ext_i),
    .mul_ce_o     (mul_ce_o),
    .mul_sclr_o   (mul_sclr_o),
    .mul_signed_o (mul_signed_o),
    .mul_p_i      (mul_p_i),
    .hi_we_o      (hi_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .stall_o      (stall_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] productOf(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Behavioural stand-in for the external multiplier core: MUL_LAT CE-qualified stages.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUL_LAT; i++) mulPipe[i] <= 64'd0;
    end else if (mul_sclr_o) begin
      for (int i = 0; i < MUL_LAT; i++) mulPipe[i] <= 64'd0;
    end else if (mul_ce_o) begin
      mulPipe[0] <= productOf(mul_signed_o, reg1_i, reg2_i);
      for (int i = 1; i < MUL_LAT; i++) mulPipe[i] <= mulPipe[i-1];
    end
  end

  assign mul_p_i = mulPipe[MUL_LAT-1];

  // Reference result {HI, LO} from the architectural definition of each op.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    case (op)
      2'b00: return productOf(1'b1, a, b);
      2'b01: return productOf(1'b0, a, b);
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b11) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_LAT;
    return (b == 32'd0) ? 1 : DIV_ITERS + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"},  64'(stall_o),      64'd0);
    checkOutput({tag, "_busy"},   64'(busy_o),       64'd0);
    checkOutput({tag, "_we"},     64'(hi_we_o),      64'd0);
    checkOutput({tag, "_ce"},     64'(mul_ce_o),     64'd0);
    checkOutput({tag, "_sclr"},   64'(mul_sclr_o),   64'd0);
    checkOutput({tag, "_signed"}, 64'(mul_signed_o), 64'd0);
    checkOutput({tag, "_hilo"},   {hi_o, lo_o},      64'd0);
  endtask

  // Runs one op from posedge+1; killCycle<0 means no flush/exception, and
  // holdCycles is how long stall_ext_i holds DONE.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int killCycle, input bit viaExcept, input int holdCycles);
    int          lat;
    int          writeCycle;
    logic [63:0] expected;
    lat        = expLatency(op, b);
    writeCycle = lat + holdCycles;
    expected   = refResult(op, a, b);
    op_i    = op;
    reg1_i  = a;
    reg2_i  = b;
    start_i = 1'b1;
    for (int k = 0; k <= writeCycle; k++) begin
      flush_i     = (k == killCycle) && !viaExcept;
      except_i    = (k == killCycle) && viaExcept;
      stall_ext_i = (k >= lat) && (k < writeCycle);
      @(negedge clk_i);
      if (k == killCycle) begin
        checkOutput("kill_stall", 64'(stall_o),    64'd0);
        checkOutput("kill_sclr",  64'(mul_sclr_o), 64'd1);
        checkOutput("kill_we",    64'(hi_we_o),    64'd0);
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        except_i = 1'b0;
        @(negedge clk_i);
        checkOutput("kill_idle",  64'(busy_o),  64'd0);
        checkOutput("kill_no_we", 64'(hi_we_o), 64'd0);
        @(posedge clk_i); #1;
        return;
      end else if (k < lat) begin
        checkOutput("run_stall",  64'(stall_o),      64'd1);
        checkOutput("run_we",     64'(hi_we_o),      64'd0);
        checkOutput("run_ce",     64'(mul_ce_o),     64'(!op[1]));
        checkOutput("run_signed", 64'(mul_signed_o), 64'(!op[1] && !op[0]));
        checkOutput("run_hilo",   {hi_o, lo_o},      64'd0);
      end else if (k < writeCycle) begin
        checkOutput("hold_stall", 64'(stall_o), 64'd0);
        checkOutput("hold_we",    64'(hi_we_o), 64'd0);
        checkOutput("hold_busy",  64'(busy_o),  64'd1);
      end else begin
        checkOutput("done_we",    64'(hi_we_o),  64'd1);
        checkOutput("done_stall", 64'(stall_o),  64'd0);
        checkOutput("done_ce",    64'(mul_ce_o), 64'd0);
        checkOutput("result",     {hi_o, lo_o},  expected);
      end
      @(posedge clk_i); #1;
    end
    start_i     = 1'b0;
    stall_ext_i = 1'b0;
  endtask

  task automatic resetMidOp(input int resetCycle);
    op_i    = 2'b00;
    reg1_i  = 32'd1234;
    reg2_i  = 32'd5678;
    start_i = 1'b1;
    repeat (resetCycle) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("rst_mid");
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("rst_after_busy", 64'(busy_o),  64'd0);
    checkOutput("rst_after_we",   64'(hi_we_o), 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rlat;
    int          rkill;

    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkAllZero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkAllZero("idle");
    @(posedge clk_i); #1;

    $display("[TB] directed operations");
    applyStimulus(MULT,  32'hFFFF_FFFE, 32'd3,         -1, 1'b0, 0);
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 0);
    applyStimulus(DIV,   32'hFFFF_FFF9, 32'd2,         -1, 1'b0, 0);
    applyStimulus(DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 0);
    applyStimulus(DIVU,  32'd5,         32'd0,         -1, 1'b0, 0);
    applyStimulus(DIVU,  32'd100,       32'd7,         10, 1'b0, 0);
    applyStimulus(MULTU, 32'd6,         32'd7,         -1, 1'b0, 0);
    applyStimulus(MULT,  32'd123,       32'd456,        4, 1'b1, 0);
    applyStimulus(MULT,  32'hFFFF_FF00, 32'd77,        -1, 1'b0, 3);
    applyStimulus(DIV,   32'd7,         32'hFFFF_FFFE, -1, 1'b0, 1);

    $display("[TB] reset in the middle of a multiply");
    resetMidOp(5);

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      rlat  = expLatency(rop, rb);
      rkill = ($urandom_range(0, 5) == 0) ? $urandom_range(0, rlat - 1) : -1;
      applyStimulus(rop, ra, rb, rkill, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
